multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 12 +
 rtl/multicycle_controller.sv | 103 ++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction-fetch and data-memory handshake bundle
interface multicycle_controller_if #(parameter int FUNCW = 8);
  logic [3:0] opcode;
  logic [FUNCW-1:0] func;
  logic inst_ready;
  logic mem_ready;
  logic inst_req;
  logic mem_req;
  logic mem_write;
  modport master(input opcode, func, inst_ready, mem_ready, output inst_req, mem_req, mem_write);
  modport slave(output opcode, func, inst_ready, mem_ready, input inst_req, mem_req, mem_write);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM with retired-instruction counter
module multicycle_controller #(
  parameter int FUNCW = 8,
  parameter int ALUOPW = FUNCW - 1,
  parameter int CNTW = 16
) (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.master bus,
  output logic setWindow,
  output logic jump,
  output logic immdSel,
  output logic memOrALU,
  output logic toWrite,
  output logic [ALUOPW-1:0] ALUop,
  output logic pc_write,
  output logic illegal,
  output logic [CNTW-1:0] instr_count
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state, nxt;
  logic [3:0] op;
  logic [FUNCW-1:0] fn;
  logic live, take, inst_req, mem_req, mem_write;
  logic is_mem, is_imm, is_r, r_wb, defined;
  logic [ALUOPW-1:0] alu_val;
  assign is_mem = op[3:1] == 3'b000;
  assign is_imm = op[3:2] == 2'b11;
  assign is_r = op == 4'b1000;
  assign r_wb = fn[FUNCW-1:FUNCW-2] == 2'b00;
  assign defined = is_mem || is_imm || is_r || op == 4'b0010 || op == 4'b0100;
  assign alu_val = op == 4'b0100 ? ALUOPW'(7'b1000111) :
                   is_r ? ALUOPW'(fn) :
                   is_imm ? ALUOPW'(5'd2 << op[1:0]) : '0;
  assign bus.inst_req = inst_req;
  assign bus.mem_req = mem_req;
  assign bus.mem_write = mem_write;
  // live keeps inst_req low for the cycle right after a reset edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH;
      op <= '0;
      fn <= '0;
      live <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      live <= 1'b1;
      if (take) begin
        op <= bus.opcode;
        fn <= bus.func;
      end
      if (pc_write && !illegal) instr_count <= instr_count + CNTW'(1);
    end
  end
  always_comb begin
    nxt = state;
    take = 1'b0;
    inst_req = 1'b0;
    mem_req = 1'b0;
    mem_write = 1'b0;
    setWindow = 1'b0;
    jump = 1'b0;
    immdSel = 1'b0;
    memOrALU = 1'b0;
    toWrite = 1'b0;
    ALUop = '0;
    pc_write = 1'b0;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        inst_req = live;
        take = live && bus.inst_ready;
        nxt = take ? DECODE : FETCH;
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        ALUop = alu_val;
        immdSel = is_imm;
        setWindow = is_r && fn[FUNCW-1];
        jump = op == 4'b0010;
        illegal = !defined;
        nxt = is_mem ? MEM : (is_imm || (is_r && r_wb)) ? WB : FETCH;
        pc_write = !is_mem && !is_imm && !(is_r && r_wb);
      end
      MEM: begin
        mem_req = 1'b1;
        mem_write = op[0];
        pc_write = bus.mem_ready && op[0];
        nxt = !bus.mem_ready ? MEM : op[0] ? FETCH : WB;
      end
      WB: begin
        toWrite = 1'b1;
        memOrALU = op == 4'b0000;
        ALUop = alu_val;
        immdSel = is_imm;
        pc_write = 1'b1;
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule
